// File: rtl/serout_if.sv
// SEROUT bus between the register decoder / baud source and the serial-output sequencer.
// SEROUT_TWOTONE_EN adds the two-tone select and tone inputs.
interface serout_if;
  logic       wr_strb;
  logic [7:0] wr_data;
  logic       bit_tick;
  logic       force_break;
`ifdef SEROUT_TWOTONE_EN
  logic       twotone;
  logic       tone1;
  logic       tone2;
`endif
  logic       sout;
  logic       irq_need;
  logic       irq_done;
  logic       busy;

  modport master (
    output wr_strb, wr_data, bit_tick, force_break,
`ifdef SEROUT_TWOTONE_EN
    output twotone, tone1, tone2,
`endif
    input  sout, irq_need, irq_done, busy
  );

  modport slave (
    input  wr_strb, wr_data, bit_tick, force_break,
`ifdef SEROUT_TWOTONE_EN
    input  twotone, tone1, tone2,
`endif
    output sout, irq_need, irq_done, busy
  );
endinterface

// File: rtl/serout_ctrl.sv
// POKEY SEROUT sequencer: holding byte -> 10-bit start/data/stop frame shifted one bit per baud tick.
// Optional two-tone output mode is enabled by defining SEROUT_TWOTONE_EN.
module serout_ctrl (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     enp,
  serout_if.slave  bus
);
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_ACTIVE  = 1'b1;
  localparam logic [9:0] SHREG_MARK = 10'h3FF;
  localparam logic [3:0] CNT_FRAME  = 4'd9;

  typedef struct packed {
    logic [0:0] st;
    logic [9:0] shreg;
    logic [3:0] cnt;
    logic [7:0] hold;
    logic       hold_full;
    logic       irq_need;
    logic       irq_done;
  } seq_t;

  localparam seq_t SEQ_RST = '{
    st:        ST_IDLE,
    shreg:     SHREG_MARK,
    cnt:       4'd0,
    hold:      8'h00,
    hold_full: 1'b0,
    irq_need:  1'b0,
    irq_done:  1'b0
  };

  seq_t seq_q, seq_d;
  logic xfer;
  logic line;

  always_comb begin
    seq_d          = seq_q;
    seq_d.irq_need = 1'b0;
    // A new frame may start from idle or exactly on the end tick of the current one (no gap).
    xfer = bus.bit_tick & seq_q.hold_full &
           ((seq_q.st == ST_IDLE) | (seq_q.cnt == 4'd0));

    if (xfer) begin
      seq_d.shreg     = {1'b1, seq_q.hold, 1'b0};
      seq_d.cnt       = CNT_FRAME;
      seq_d.st        = ST_ACTIVE;
      seq_d.hold_full = 1'b0;
      seq_d.irq_need  = 1'b1;
      seq_d.irq_done  = 1'b0;
    end else if (bus.bit_tick && (seq_q.st == ST_ACTIVE)) begin
      if (seq_q.cnt != 4'd0) begin
        seq_d.shreg = {1'b1, seq_q.shreg[9:1]};
        seq_d.cnt   = seq_q.cnt - 4'd1;
      end else begin
        seq_d.st       = ST_IDLE;
        seq_d.irq_done = 1'b1;
        seq_d.shreg    = SHREG_MARK;
      end
    end

    // Write lands after any transfer so a same-edge transfer ships the old byte.
    if (bus.wr_strb) begin
      seq_d.hold      = bus.wr_data;
      seq_d.hold_full = 1'b1;
      seq_d.irq_done  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   seq_q <= SEQ_RST;
    else if (enp) seq_q <= seq_d;
  end

  assign line = seq_q.shreg[0];

`ifdef SEROUT_TWOTONE_EN
  assign bus.sout = bus.force_break ? 1'b0 :
                    (bus.twotone ? (line ? bus.tone1 : bus.tone2) : line);
`else
  assign bus.sout = bus.force_break ? 1'b0 : line;
`endif

  assign bus.irq_need = seq_q.irq_need;
  assign bus.irq_done = seq_q.irq_done;
  assign bus.busy     = (seq_q.st == ST_ACTIVE);
endmodule

// File: tb/tb_serout_ctrl.sv
// Randomized + directed bench for serout_ctrl against a frame-position reference model.
module tb_serout_ctrl;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic enp   = 1'b0;

  serout_if bus();

  serout_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .enp   (enp),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic got   [0:31];
  logic needv [0:31];
  logic donev [0:31];
  logic busyv [0:31];

  // Reference model: a frame is "position t within {start, d0..d7, stop}".
  bit         m_act, m_full, m_need, m_done;
  int         m_t;
  logic [7:0] m_byte, m_hold;

  function automatic logic m_line();
    if (!m_act)   return 1'b1;
    if (m_t == 0) return 1'b0;
    if (m_t == 9) return 1'b1;
    return m_byte[m_t-1];
  endfunction

  function automatic logic exp_sout();
    logic l;
    l = m_line();
`ifdef SEROUT_TWOTONE_EN
    if (bus.twotone) l = l ? bus.tone1 : bus.tone2;
`endif
    return bus.force_break ? 1'b0 : l;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 0; m_full = 0; m_need = 0; m_done = 0; m_t = 0;
      m_byte = 8'h00; m_hold = 8'h00;
    end else if (enp) begin
      bit x;
      x = bus.bit_tick && m_full && (!m_act || m_t == 9);
      m_need = x;
      if (x) begin
        m_byte = m_hold; m_t = 0; m_act = 1; m_full = 0; m_done = 0;
      end else if (m_act && bus.bit_tick) begin
        if (m_t < 9) m_t = m_t + 1;
        else begin m_act = 0; m_done = 1; end
      end
      if (bus.wr_strb) begin
        m_hold = bus.wr_data; m_full = 1; m_done = 0;
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n && chk_en) begin
      chk("model.sout",     bus.sout,     exp_sout());
      chk("model.irq_need", bus.irq_need, m_need);
      chk("model.irq_done", bus.irq_done, m_done);
      chk("model.busy",     bus.busy,     m_act);
    end
  end

  task automatic step(input bit tk, input bit wr, input logic [7:0] d);
    @(negedge clk);
    enp = 1'b1; bus.bit_tick = tk; bus.wr_strb = wr; bus.wr_data = d;
    @(negedge clk);
    // Noise on non-enable cycles must be ignored.
    enp = 1'b0;
    bus.bit_tick = 1'($urandom); bus.wr_strb = 1'($urandom); bus.wr_data = 8'($urandom);
  endtask

  // n ticks, one every 4th enable; optional write at tick wr_at (same edge or the next enable).
  task automatic run(input int n, input int wr_at, input bit same, input logic [7:0] d);
    for (int k = 0; k < n; k++) begin
      step(1'b1, same && (k == wr_at), d);
      got[k] = bus.sout; needv[k] = bus.irq_need; donev[k] = bus.irq_done; busyv[k] = bus.busy;
      step(1'b0, !same && (k == wr_at), d);
      step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, ".sout"},     bus.sout,     1'b1);
    chk({tag, ".irq_need"}, bus.irq_need, 1'b0);
    chk({tag, ".irq_done"}, bus.irq_done, 1'b0);
    chk({tag, ".busy"},     bus.busy,     1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  logic e_a5 [0:9]  = '{0,1,0,1,0,0,1,0,1,1};
  logic e_3c [0:19] = '{0,0,0,1,1,1,1,0,0,1, 0,0,0,0,0,1,1,1,1,1};
  logic e_55 [0:19] = '{0,1,0,1,0,1,0,1,0,1, 0,1,0,0,0,0,0,0,1,1};

  initial begin
    bus.wr_strb = 0; bus.wr_data = 0; bus.bit_tick = 0; bus.force_break = 0;
`ifdef SEROUT_TWOTONE_EN
    bus.twotone = 0; bus.tone1 = 0; bus.tone2 = 0;
`endif
    repeat (3) @(negedge clk);
    check_reset_outs("rst.held");
    rst_n = 1'b1;
    chk_en = 1'b1;
    step(1'b1, 1'b0, 8'h00);
    check_reset_outs("rst.released");

    // 0xA5 frame, literal line sequence
    step(1'b0, 1'b1, 8'hA5);
    run(11, -1, 1'b0, 8'h00);
    for (int k = 0; k < 10; k++) chk($sformatf("a5.bit%0d", k), got[k], e_a5[k]);
    chk("a5.need_t1",  needv[0], 1'b1);
    chk("a5.need_t2",  needv[1], 1'b0);
    chk("a5.done_t10", donev[9], 1'b0);
    chk("a5.done_t11", donev[10], 1'b1);
    chk("a5.busy_t11", busyv[10], 1'b0);
    chk("a5.idle_t11", got[10], 1'b1);

    // reset mid-frame
    step(1'b0, 1'b1, 8'h00);
    run(5, -1, 1'b0, 8'h00);
    chk("mid.busy_before", bus.busy, 1'b1);
    @(negedge clk); rst_n = 1'b0; #1;
    check_reset_outs("mid.rst");
    @(negedge clk); rst_n = 1'b1;

    // 0x3C with 0xF0 written mid-frame: back-to-back, no idle bit
    step(1'b0, 1'b1, 8'h3C);
    run(21, 3, 1'b0, 8'hF0);
    for (int k = 0; k < 20; k++) chk($sformatf("b2b.bit%0d", k), got[k], e_3c[k]);
    chk("b2b.need_t11", needv[10], 1'b1);
    chk("b2b.busy_t11", busyv[10], 1'b1);
    chk("b2b.done_t11", donev[10], 1'b0);
    chk("b2b.done_t20", donev[19], 1'b0);
    chk("b2b.done_t21", donev[20], 1'b1);
    chk("b2b.idle_t21", got[20], 1'b1);

    // same-edge write 0x81 on the transfer of 0x55
    step(1'b0, 1'b1, 8'h55);
    run(21, 0, 1'b1, 8'h81);
    for (int k = 0; k < 20; k++) chk($sformatf("same.bit%0d", k), got[k], e_55[k]);
    chk("same.need_t1",  needv[0], 1'b1);
    chk("same.done_t1",  donev[0], 1'b0);
    chk("same.need_t11", needv[10], 1'b1);
    chk("same.done_t21", donev[20], 1'b1);

    // force_break over ticks 2..5 of a 0xFF frame
    step(1'b0, 1'b1, 8'hFF);
    for (int k = 0; k < 11; k++) begin
      bus.force_break = (k >= 1 && k <= 4);
      step(1'b1, 1'b0, 8'h00);
      if (k >= 1 && k <= 4) chk($sformatf("brk.low%0d", k), bus.sout, 1'b0);
      else if (k >= 5)      chk($sformatf("brk.bit%0d", k), bus.sout, 1'b1);
      chk($sformatf("brk.busy%0d", k), bus.busy, k < 10);
      step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);
    end
    bus.force_break = 1'b0;
    chk("brk.done", bus.irq_done, 1'b1);

`ifdef SEROUT_TWOTONE_EN
    bus.twotone = 1; bus.tone1 = 1; bus.tone2 = 0;
    step(1'b0, 1'b1, 8'h00);
    run(10, -1, 1'b0, 8'h00);
    for (int k = 0; k < 10; k++) chk($sformatf("tt.bit%0d", k), got[k], k == 9);
    bus.twotone = 0;
`endif

    // randomized traffic; the model compare covers every cycle
    for (int i = 0; i < 500; i++) begin
      bus.force_break = ($urandom_range(0, 15) == 0);
`ifdef SEROUT_TWOTONE_EN
      bus.twotone = 1'($urandom); bus.tone1 = 1'($urandom); bus.tone2 = 1'($urandom);
`endif
      if ($urandom_range(0, 249) == 0) begin
        @(negedge clk); bus.force_break = 1'b0; rst_n = 1'b0; #1;
        check_reset_outs("rnd.rst");
        @(negedge clk); rst_n = 1'b1;
      end
      step($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, 8'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
